// File: rtl/nvdla_cdp_dp_rdma_ingress_pkg.sv
// rtl/nvdla_cdp_dp_rdma_ingress_pkg.sv - shared pd layout, precision codes and FSM states for the CDP RDMA ingress
package nvdla_cdp_dp_rdma_ingress_pkg;

  localparam int PD_WIDTH     = 87;
  localparam int NUM_LANES    = 8;
  localparam int LANE_W       = 16;
  localparam int PD_DATA_W    = 64;
  localparam int PD_LINE_END  = 64;
  localparam int PD_SURF_END  = 65;
  localparam int PD_LAYER_END = 66;
  localparam int PD_NEM_LSB   = 67;
  localparam int PD_NEM_W     = 3;
  localparam int PD_RSVD_LSB  = 70;

  typedef enum logic [1:0] {
    PREC_INT8  = 2'd0,
    PREC_INT16 = 2'd1,
    PREC_FP16  = 2'd2,
    PREC_RSVD  = 2'd3
  } prec_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_CLR = 3'd4
  } state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reserved encoding falls back to int8 unpacking.
  function automatic logic is_wide_prec(input prec_e p);
    return (p == PREC_INT16) || (p == PREC_FP16);
  endfunction

endpackage

// File: rtl/nvdla_cdp_dp_rdma_ingress_if.sv
// rtl/nvdla_cdp_dp_rdma_ingress_if.sv - rdma2dp input stream and dp output stream bundle
interface nvdla_cdp_dp_rdma_ingress_if;
  import nvdla_cdp_dp_rdma_ingress_pkg::*;

  logic                          cdp_rdma2dp_valid;
  logic                          cdp_rdma2dp_ready;
  logic [PD_WIDTH-1:0]           cdp_rdma2dp_pd;
  logic                          dp_valid;
  logic                          dp_ready;
  logic [NUM_LANES*LANE_W-1:0]   dp_data;
  logic [NUM_LANES-1:0]          dp_mask;
  logic                          dp_line_end;
  logic                          dp_surf_end;
  logic                          dp_layer_end;

  modport slave (
    input  cdp_rdma2dp_valid, cdp_rdma2dp_pd, dp_ready,
    output cdp_rdma2dp_ready, dp_valid, dp_data, dp_mask,
           dp_line_end, dp_surf_end, dp_layer_end
  );

  modport master (
    output cdp_rdma2dp_valid, cdp_rdma2dp_pd, dp_ready,
    input  cdp_rdma2dp_ready, dp_valid, dp_data, dp_mask,
           dp_line_end, dp_surf_end, dp_layer_end
  );

endinterface

// File: rtl/nvdla_cdp_dp_skid2.sv
// rtl/nvdla_cdp_dp_skid2.sv - 2-entry fall-through valid/ready skid FIFO with synchronous flush
module nvdla_cdp_dp_skid2 #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push_valid,
  output logic         o_push_ready,
  input  logic [W-1:0] i_push_data,
  output logic         o_pop_valid,
  input  logic         i_pop_ready,
  output logic [W-1:0] o_pop_data,
  output logic         o_empty
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_full;
  logic         w_bypass;
  logic         w_wr;
  logic         w_rd;

  assign o_empty      = (r_count == 2'd0);
  assign w_full       = (r_count == FULL_CNT);
  assign o_push_ready = !w_full;

  // An empty FIFO passes the push straight through so an idle pipe adds no cycle.
  assign o_pop_valid = !o_empty || i_push_valid;
  assign o_pop_data  = o_empty ? i_push_data : r_mem[r_rd_ptr];
  assign w_bypass    = o_empty && i_pop_ready;
  assign w_wr        = i_push_valid && !w_bypass;
  assign w_rd        = !o_empty && i_pop_ready;

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

endmodule

// File: rtl/nvdla_cdp_dp_rdma_ingress.sv
// rtl/nvdla_cdp_dp_rdma_ingress.sv - CDP datapath ingress: skid buffer, lane unpack, layer FSM and beat accounting
module nvdla_cdp_dp_rdma_ingress #(
  parameter int FIFO_DEPTH = 2,
  parameter int PD_W       = 87,
  parameter int LANES      = 8
) (
  input  logic                               i_nvdla_core_clk,
  input  logic                               i_nvdla_core_rstn,
  nvdla_cdp_dp_rdma_ingress_if.slave         io_bus,
  input  logic                               i_reg2dp_op_en,
  input  logic [1:0]                         i_reg2dp_input_data,
  input  logic [31:0]                        i_cfg_beat_total,
  output logic                               o_dp2reg_done,
  output logic [31:0]                        o_dp2reg_beat_cnt,
  output logic                               o_dp2reg_len_err
);
  import nvdla_cdp_dp_rdma_ingress_pkg::*;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_op_en_d;
  logic               r_layer_end_seen;
  logic [31:0]        r_beat_cnt;
  logic               r_len_err;

  logic               r_dp_valid;
  logic [LANES*16-1:0] r_dp_data;
  logic [LANES-1:0]   r_dp_mask;
  logic               r_dp_line_end;
  logic               r_dp_surf_end;
  logic               r_dp_layer_end;

  logic               w_op_rise;
  logic               w_abort;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_in_layer_end;
  logic [2:0]         w_in_nem;
  logic               w_wide;
  logic               w_clamp_err;
  logic [31:0]        w_cnt_inc;
  logic               w_fifo_push_ready;
  logic               w_fifo_empty;
  logic               w_pop_valid;
  logic [PD_W-1:0]    w_pop_pd;
  logic               w_out_free;
  logic [2:0]         w_nem;
  logic [2:0]         w_nem16;
  logic [LANES*16-1:0] w_lanes;
  logic [LANES-1:0]   w_mask;
  logic               w_unused_rsvd;

  assign w_op_rise      = i_reg2dp_op_en && !r_op_en_d;
  assign w_abort        = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !i_reg2dp_op_en;
  assign w_in_ready     = (r_state == ST_RUN) && i_reg2dp_op_en && w_fifo_push_ready && !r_layer_end_seen;
  assign w_accept       = io_bus.cdp_rdma2dp_valid && w_in_ready;
  assign w_in_layer_end = io_bus.cdp_rdma2dp_pd[PD_LAYER_END];
  assign w_in_nem       = io_bus.cdp_rdma2dp_pd[PD_NEM_LSB +: PD_NEM_W];
  assign w_wide         = is_wide_prec(prec_e'(i_reg2dp_input_data));
  assign w_clamp_err    = w_accept && w_wide && (w_in_nem > 3'd3);
  assign w_cnt_inc      = sat_inc32(r_beat_cnt);
  assign w_out_free     = !r_dp_valid || io_bus.dp_ready;
  assign w_unused_rsvd  = ^w_pop_pd[PD_W-1:PD_RSVD_LSB];

  nvdla_cdp_dp_skid2 #(
    .DEPTH (FIFO_DEPTH),
    .W     (PD_W)
  ) u_skid (
    .i_clk        (i_nvdla_core_clk),
    .i_rst_n      (i_nvdla_core_rstn),
    .i_flush      (w_abort),
    .i_push_valid (w_accept),
    .o_push_ready (w_fifo_push_ready),
    .i_push_data  (io_bus.cdp_rdma2dp_pd),
    .o_pop_valid  (w_pop_valid),
    .i_pop_ready  (w_out_free),
    .o_pop_data   (w_pop_pd),
    .o_empty      (w_fifo_empty)
  );

  // Wide precisions only carry four lanes per beat; extra elements are clamped away.
  always_comb begin
    w_lanes = '0;
    w_mask  = '0;
    w_nem   = w_pop_pd[PD_NEM_LSB +: PD_NEM_W];
    w_nem16 = (w_nem > 3'd3) ? 3'd3 : w_nem;
    if (w_wide) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) <= w_nem16) begin
          w_lanes[16*i +: 16] = w_pop_pd[16*i +: 16];
          w_mask[i]           = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (3'(i) <= w_nem) begin
          w_lanes[16*i +: 16] = {{8{w_pop_pd[8*i+7]}}, w_pop_pd[8*i +: 8]};
          w_mask[i]           = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_op_rise) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_abort)                          w_state_nxt = ST_IDLE;
        else if (w_accept && w_in_layer_end)  w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_abort)                          w_state_nxt = ST_IDLE;
        else if (w_fifo_empty && w_out_free)  w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!i_reg2dp_op_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_nvdla_core_clk or negedge i_nvdla_core_rstn) begin
    if (!i_nvdla_core_rstn) begin
      r_state          <= ST_IDLE;
      r_op_en_d        <= 1'b0;
      r_layer_end_seen <= 1'b0;
      r_beat_cnt       <= 32'd0;
      r_len_err        <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op_en_d <= i_reg2dp_op_en;
      if ((r_state == ST_IDLE) && w_op_rise) begin
        r_layer_end_seen <= 1'b0;
        r_beat_cnt       <= 32'd0;
        r_len_err        <= 1'b0;
      end else begin
        if (w_accept) begin
          r_beat_cnt <= w_cnt_inc;
          if (w_in_layer_end) r_layer_end_seen <= 1'b1;
        end
        if (w_clamp_err || (w_accept && w_in_layer_end && (w_cnt_inc != i_cfg_beat_total))) begin
          r_len_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_nvdla_core_clk or negedge i_nvdla_core_rstn) begin
    if (!i_nvdla_core_rstn) begin
      r_dp_valid     <= 1'b0;
      r_dp_data      <= '0;
      r_dp_mask      <= '0;
      r_dp_line_end  <= 1'b0;
      r_dp_surf_end  <= 1'b0;
      r_dp_layer_end <= 1'b0;
    end else if (w_abort) begin
      r_dp_valid     <= 1'b0;
      r_dp_data      <= '0;
      r_dp_mask      <= '0;
      r_dp_line_end  <= 1'b0;
      r_dp_surf_end  <= 1'b0;
      r_dp_layer_end <= 1'b0;
    end else if (w_out_free) begin
      r_dp_valid <= w_pop_valid;
      if (w_pop_valid) begin
        r_dp_data      <= w_lanes;
        r_dp_mask      <= w_mask;
        r_dp_line_end  <= w_pop_pd[PD_LINE_END];
        r_dp_surf_end  <= w_pop_pd[PD_SURF_END];
        r_dp_layer_end <= w_pop_pd[PD_LAYER_END];
      end
    end
  end

  assign io_bus.cdp_rdma2dp_ready = w_in_ready;
  assign io_bus.dp_valid          = r_dp_valid;
  assign io_bus.dp_data           = r_dp_data;
  assign io_bus.dp_mask           = r_dp_mask;
  assign io_bus.dp_line_end       = r_dp_line_end;
  assign io_bus.dp_surf_end       = r_dp_surf_end;
  assign io_bus.dp_layer_end      = r_dp_layer_end;

  assign o_dp2reg_done     = (r_state == ST_DONE);
  assign o_dp2reg_beat_cnt = r_beat_cnt;
  assign o_dp2reg_len_err  = r_len_err;

endmodule
